// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Build option IMEM_BYTE_WIDE_EN selects the byte-wide (1024x8) memory target.
package imem_loader_pkg;

  localparam int IMEM_DEPTH_WORDS = 256;
  localparam int IMEM_BYTE_ADDR_W = 10;
  localparam int IMEM_WORD_IDX_W  = IMEM_BYTE_ADDR_W - 2;

`ifdef IMEM_BYTE_WIDE_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BYTES = 3'd2,
    ST_DONE  = 3'd4
  } loader_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;
`endif

endpackage

// File: rtl/imem_byte_serializer.sv
// Splits one accepted 32-bit word into four little-endian byte writes.
// Only instantiated when IMEM_BYTE_WIDE_EN is defined.
module imem_byte_serializer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [31:0]                 word,
  input  logic [IMEM_WORD_IDX_W-1:0]  word_idx,
  output logic                        byte_we,
  output logic [IMEM_BYTE_ADDR_W-1:0] byte_addr,
  output logic [7:0]                  byte_data,
  output logic                        last_byte
);

  logic                       active_q, active_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [31:0]                word_q, word_d;
  logic [IMEM_WORD_IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    idx_d    = idx_q;
    if (load) begin
      active_d = 1'b1;
      cnt_d    = '0;
      word_d   = word;
      idx_d    = word_idx;
    end else if (active_q) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    case (cnt_q)
      2'd0:    byte_data = word_q[7:0];
      2'd1:    byte_data = word_q[15:8];
      2'd2:    byte_data = word_q[23:16];
      default: byte_data = word_q[31:24];
    endcase
  end

  assign byte_we   = active_q;
  assign byte_addr = {idx_q, cnt_q};
  assign last_byte = active_q && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams host instruction words into the instruction memory and holds the
// CPU in reset until loading completes. IMEM_BYTE_WIDE_EN selects byte writes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int CNT_W       = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_W-1:0]            word_count,
  input  logic                        in_valid,
  input  logic [31:0]                 in_data,
  output logic                        in_ready,
  output logic                        mem_we,
  output logic [IMEM_BYTE_ADDR_W-1:0] mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic                        cpu_reset,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            loaded_count
);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] loaded_q, loaded_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cpu_reset_q, cpu_reset_d;

  logic [CNT_W-1:0] clamped;
  logic [CNT_W-1:0] loaded_inc;
  logic             accept;

  assign clamped    = (word_count > CNT_W'(DEPTH_WORDS)) ? CNT_W'(DEPTH_WORDS) : word_count;
  assign loaded_inc = loaded_q + CNT_W'(1);
  assign accept     = in_valid && in_ready_q;

`ifdef IMEM_BYTE_WIDE_EN
  logic                        ser_load;
  logic                        ser_last;
  logic                        ser_we;
  logic [IMEM_BYTE_ADDR_W-1:0] ser_addr;
  logic [7:0]                  ser_data;

  imem_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .word      (in_data),
    .word_idx  (IMEM_WORD_IDX_W'(loaded_q)),
    .byte_we   (ser_we),
    .byte_addr (ser_addr),
    .byte_data (ser_data),
    .last_byte (ser_last)
  );
`else
  logic                        mem_we_q, mem_we_d;
  logic [IMEM_BYTE_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]                 mem_wdata_q, mem_wdata_d;
`endif

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    loaded_d    = loaded_q;
    in_ready_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    cpu_reset_d = cpu_reset_q;
`ifdef IMEM_BYTE_WIDE_EN
    ser_load    = 1'b0;
`else
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          target_d = clamped;
          loaded_d = '0;
          if (clamped == '0) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = ST_LOAD;
            in_ready_d  = 1'b1;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            cpu_reset_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        in_ready_d = 1'b1;
        if (accept) begin
          loaded_d = loaded_inc;
`ifdef IMEM_BYTE_WIDE_EN
          ser_load   = 1'b1;
          state_d    = ST_BYTES;
          in_ready_d = 1'b0;
`else
          mem_we_d    = 1'b1;
          mem_addr_d  = IMEM_BYTE_ADDR_W'(loaded_q);
          mem_wdata_d = in_data;
          if (loaded_inc == target_q) begin
            state_d    = ST_DRAIN;
            in_ready_d = 1'b0;
          end
`endif
        end
      end
`ifdef IMEM_BYTE_WIDE_EN
      // The final byte write ends at this edge, so release the core here.
      ST_BYTES: begin
        if (ser_last) begin
          if (loaded_q == target_q) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d    = ST_LOAD;
            in_ready_d = 1'b1;
          end
        end
      end
`else
      ST_DRAIN: begin
        state_d     = ST_DONE;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        cpu_reset_d = 1'b0;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      loaded_q    <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      loaded_q    <= loaded_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

`ifdef IMEM_BYTE_WIDE_EN
  assign mem_we    = ser_we;
  assign mem_addr  = ser_addr;
  assign mem_wdata = {24'h0, ser_data};
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`endif

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cpu_reset    = cpu_reset_q;
  assign loaded_count = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus hand sequences
// for clamping and mid-session reset (word mode) or byte serialization.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic [8:0]  loaded_count;

  int passed = 0;
  int total  = 0;

  imem_loader #(.DEPTH_WORDS(256), .CNT_W(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .word_count   (word_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .loaded_count (loaded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [8:0]  wc;
    logic        valid;
    logic [31:0] data;
    logic        e_ready;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_cpurst;
    logic        e_busy;
    logic        e_done;
    logic [8:0]  e_loaded;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic st, logic [8:0] wc, logic v, logic [31:0] d,
                               logic er, logic ew, logic [9:0] ea, logic [31:0] ed,
                               logic ec, logic eb, logic edn, logic [8:0] el);
    vec_t r;
    r.start = st; r.wc = wc; r.valid = v; r.data = d;
    r.e_ready = er; r.e_we = ew; r.e_addr = ea; r.e_wdata = ed;
    r.e_cpurst = ec; r.e_busy = eb; r.e_done = edn; r.e_loaded = el;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic st, input logic [8:0] wc, input logic v, input logic [31:0] d);
    @(negedge clk);
    start = st; word_count = wc; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input vec_t r);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(r.e_ready));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(r.e_we));
    if (r.e_we) begin
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(r.e_addr));
      chk({tag, " mem_wdata"}, mem_wdata, r.e_wdata);
    end
    chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'(r.e_cpurst));
    chk({tag, " busy"}, 32'(busy), 32'(r.e_busy));
    chk({tag, " done"}, 32'(done), 32'(r.e_done));
    chk({tag, " loaded_count"}, 32'(loaded_count), 32'(r.e_loaded));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " loaded_count"}, 32'(loaded_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

`ifndef IMEM_BYTE_WIDE_EN
    // zero-length session from IDLE; in_valid is ignored while in_ready is low
    tbl.push_back(mkv(1, 0, 1, 32'h55555555, 0, 0, 0, 0,            0, 0, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 32'h55555555, 0, 0, 0, 0,            0, 0, 1, 0));
    // three back-to-back words
    tbl.push_back(mkv(1, 3, 0, 32'h0,        1, 0, 0, 0,            1, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 32'h20080005, 1, 1, 0, 32'h20080005, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 32'h20090007, 1, 1, 1, 32'h20090007, 1, 1, 0, 2));
    tbl.push_back(mkv(0, 0, 1, 32'h01095020, 0, 1, 2, 32'h01095020, 1, 1, 0, 3));
    tbl.push_back(mkv(0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0,            0, 0, 1, 3));
    tbl.push_back(mkv(0, 0, 0, 32'h0,        0, 0, 0, 0,            0, 0, 1, 3));
    // host stalls 1,0,0,1 with a stray start inside LOAD
    tbl.push_back(mkv(1, 2, 0, 32'h0,        1, 0, 0, 0,            1, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 32'hA0000001, 1, 1, 0, 32'hA0000001, 1, 1, 0, 1));
    tbl.push_back(mkv(1, 5, 0, 32'h0,        1, 0, 0, 0,            1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 32'h0,        1, 0, 0, 0,            1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 32'hA0000002, 0, 1, 1, 32'hA0000002, 1, 1, 0, 2));
    tbl.push_back(mkv(0, 0, 0, 32'h0,        0, 0, 0, 0,            0, 0, 1, 2));
`else
    // words 0x11223344 then 0xAABBCCDD (word 1 lands at bytes 4..7)
    tbl.push_back(mkv(1, 2, 0, 32'h0,        1, 0, 0, 0,     1, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 32'h11223344, 0, 1, 0, 32'h44, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 32'hAABBCCDD, 0, 1, 1, 32'h33, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 32'hAABBCCDD, 0, 1, 2, 32'h22, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 32'hAABBCCDD, 0, 1, 3, 32'h11, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 32'hAABBCCDD, 1, 0, 0, 0,     1, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 32'hAABBCCDD, 0, 1, 4, 32'hDD, 1, 1, 0, 2));
    tbl.push_back(mkv(0, 0, 1, 32'h0,        0, 1, 5, 32'hCC, 1, 1, 0, 2));
    tbl.push_back(mkv(0, 0, 1, 32'h0,        0, 1, 6, 32'hBB, 1, 1, 0, 2));
    tbl.push_back(mkv(0, 0, 1, 32'h0,        0, 1, 7, 32'hAA, 1, 1, 0, 2));
    tbl.push_back(mkv(0, 0, 0, 32'h0,        0, 0, 0, 0,     0, 0, 1, 2));
    // zero-length restart from DONE
    tbl.push_back(mkv(1, 0, 1, 32'h0,        0, 0, 0, 0,     0, 0, 1, 0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].wc, tbl[i].valid, tbl[i].data);
      chk_vec($sformatf("vec%0d", i), tbl[i]);
    end

`ifndef IMEM_BYTE_WIDE_EN
    // word_count above depth clamps to 256 words
    drive(1, 9'd300, 0, 32'h0);
    chk_vec("clamp start", mkv(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 1, 32'hC0000000 | 32'(i));
      chk_vec($sformatf("clamp w%0d", i),
              mkv(0, 0, 0, 0, (i < 255) ? 1'b1 : 1'b0, 1, 10'(i),
                  32'hC0000000 | 32'(i), 1, 1, 0, 9'(i + 1)));
    end
    drive(0, 0, 1, 32'hC0000100);
    chk_vec("clamp extra1", mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'd256));
    drive(0, 0, 1, 32'hC0000101);
    chk_vec("clamp extra2", mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'd256));

    // async reset after 2 of 5 words, then restart from address 0
    drive(1, 9'd5, 0, 32'h0);
    drive(0, 0, 1, 32'hB0000000);
    drive(0, 0, 1, 32'hB0000001);
    chk_vec("rst pre", mkv(0, 0, 0, 0, 1, 1, 1, 32'hB0000001, 1, 1, 0, 2));
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("rst async");
    @(negedge clk);
    reset = 1'b0;
    drive(1, 9'd5, 0, 32'h0);
    chk_vec("rst restart", mkv(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    drive(0, 0, 1, 32'hB0000002);
    chk_vec("rst first", mkv(0, 0, 0, 0, 1, 1, 0, 32'hB0000002, 1, 1, 0, 1));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
